// File: rtl/axi_wr_responder.sv
// Terminating AXI write slave: queues AW requests, sinks the matching W burst,
// checks burst integrity and returns one B response per burst. Good and bad
// bursts are counted with saturating counters.
module axi_wr_responder #(
   parameter int ID_W       = 4,
   parameter int LEN_W      = 8,
   parameter int DATA_BYTES = 4,
   parameter int AW_DEPTH   = 4,
   parameter int B_LATENCY  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ID_W-1:0]         awid,
   input  logic [LEN_W-1:0]        awlen,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [ID_W-1:0]         wid,
   input  logic [8*DATA_BYTES-1:0] wdata,
   input  logic [DATA_BYTES-1:0]   wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [ID_W-1:0]         bid,
   output logic [1:0]              bresp,
   output logic [15:0]             cnt_ok,
   output logic [15:0]             cnt_err
);

   localparam int PTR_W = $clog2(AW_DEPTH);
   localparam int LAT_W = $clog2(B_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT, S_RESP} state_t;

   // AW queue storage and pointers (extra MSB separates full from empty)
   logic [ID_W+LEN_W-1:0] q_mem [AW_DEPTH];
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic                  q_full;
   logic                  q_empty;
   logic                  push;
   logic                  pop;
   logic [ID_W-1:0]       head_id;
   logic [LEN_W-1:0]      head_len;

   // Burst tracking
   state_t                state;
   logic [ID_W-1:0]       cur_id;
   logic [LEN_W-1:0]      cur_len;
   logic [LEN_W-1:0]      beat_cnt;
   logic                  err;
   logic [LAT_W-1:0]      lat_cnt;
   logic                  beat_acc;
   logic                  beat_err;
   logic                  burst_end;

   // Payload is sunk; fold it into one bit so it is visibly consumed
   logic                  unused_w;
   assign unused_w = ^{wdata, wstrb};

   assign q_empty  = (wr_ptr == rd_ptr);
   assign q_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign awready  = ~q_full;
   assign push     = awvalid & ~q_full;
   assign {head_id, head_len} = q_mem[rd_ptr[PTR_W-1:0]];

   // A beat is bad if its ID differs or wlast disagrees with the beat position
   assign beat_acc  = (state == S_DATA) & wvalid & wready;
   assign beat_err  = (wid != cur_id) | (wlast != (beat_cnt == cur_len));
   assign burst_end = beat_acc & (wlast | (beat_cnt == cur_len));
   assign pop       = burst_end;

   // Queue storage write; no reset needed on the data array
   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[wr_ptr[PTR_W-1:0]] <= {awid, awlen};
      end
   end

   // Queue pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Burst FSM with registered handshake outputs and saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cur_id   <= '0;
         cur_len  <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
         lat_cnt  <= '0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bid      <= '0;
         bresp    <= 2'b00;
         cnt_ok   <= '0;
         cnt_err  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               wready <= 1'b0;
               if (!q_empty) begin
                  cur_id   <= head_id;
                  cur_len  <= head_len;
                  beat_cnt <= '0;
                  err      <= 1'b0;
                  wready   <= 1'b1;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  err      <= err | beat_err;
                  if (burst_end) begin
                     wready  <= 1'b0;
                     bid     <= cur_id;
                     lat_cnt <= LAT_W'(B_LATENCY - 1);
                     if (B_LATENCY == 1) begin
                        bvalid <= 1'b1;
                        bresp  <= (err | beat_err) ? 2'b10 : 2'b00;
                        state  <= S_RESP;
                     end else begin
                        state  <= S_WAIT;
                     end
                  end
               end
            end
            S_WAIT: begin
               wready  <= 1'b0;
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == LAT_W'(1)) begin
                  bvalid <= 1'b1;
                  bresp  <= err ? 2'b10 : 2'b00;
                  state  <= S_RESP;
               end
            end
            S_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  if (bresp == 2'b00) begin
                     if (cnt_ok != 16'hFFFF) cnt_ok <= cnt_ok + 1'b1;
                  end else begin
                     if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 1'b1;
                  end
                  if (!q_empty) begin
                     cur_id   <= head_id;
                     cur_len  <= head_len;
                     beat_cnt <= '0;
                     err      <= 1'b0;
                     wready   <= 1'b1;
                     state    <= S_DATA;
                  end else begin
                     state    <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_responder.sv
// Bench for axi_wr_responder: directed scenarios followed by randomized bursts.
// Expected B responses are queued when a burst is planned; a monitor pops and
// compares them whenever the DUT completes a B handshake.
module tb_axi_wr_responder;

   localparam int ID_W       = 4;
   localparam int LEN_W      = 8;
   localparam int DATA_BYTES = 4;
   localparam int AW_DEPTH   = 4;
   localparam int B_LATENCY  = 2;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] len;
   } aw_t;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } b_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    awvalid = 1'b0;
   logic                    awready;
   logic [ID_W-1:0]         awid = '0;
   logic [LEN_W-1:0]        awlen = '0;
   logic                    wvalid = 1'b0;
   logic                    wready;
   logic [ID_W-1:0]         wid = '0;
   logic [8*DATA_BYTES-1:0] wdata = '0;
   logic [DATA_BYTES-1:0]   wstrb = '0;
   logic                    wlast = 1'b0;
   logic                    bvalid;
   logic                    bready = 1'b0;
   logic [ID_W-1:0]         bid;
   logic [1:0]              bresp;
   logic [15:0]             cnt_ok;
   logic [15:0]             cnt_err;

   int  n_cmp = 0;
   int  n_fail = 0;
   int  m_ok = 0;
   int  m_err = 0;
   int  bready_mode = 1;   // 0 random, 1 always high, 2 always low
   aw_t aw_q[$];
   b_t  exp_q[$];

   always #5 clk = ~clk;

   axi_wr_responder #(
      .ID_W(ID_W), .LEN_W(LEN_W), .DATA_BYTES(DATA_BYTES),
      .AW_DEPTH(AW_DEPTH), .B_LATENCY(B_LATENCY)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
      .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .cnt_ok(cnt_ok), .cnt_err(cnt_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event (actual=event required=none)", name);
   endtask

   // Response monitor: compares every presented B against the scoreboard head
   task automatic monitor();
      bit had_stall = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_ok = 0;
            m_err = 0;
            had_stall = 0;
         end else begin
            if (had_stall && !bvalid) note_fail("b_dropped_without_ready");
            had_stall = 0;
            if (bvalid) begin
               if (exp_q.size() == 0) begin
                  note_fail("b_unexpected");
               end else begin
                  chk("b_bid", 32'(bid), 32'(exp_q[0].id));
                  chk("b_bresp", 32'(bresp), 32'(exp_q[0].resp));
                  if (bready) begin
                     b_t e = exp_q.pop_front();
                     chk("cnt_ok_pre", 32'(cnt_ok), 32'(m_ok));
                     chk("cnt_err_pre", 32'(cnt_err), 32'(m_err));
                     $display("B id=%0h resp=%0h ok=%0d err=%0d", bid, bresp, cnt_ok, cnt_err);
                     if (e.resp == 2'b00) begin
                        if (m_ok < 65535) m_ok++;
                     end else begin
                        if (m_err < 65535) m_err++;
                     end
                  end else begin
                     had_stall = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic bready_drv();
      forever begin
         @(posedge clk);
         #1;
         case (bready_mode)
            1:       bready = 1'b1;
            2:       bready = 1'b0;
            default: bready = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic aw_send(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
      int t = 0;
      aw_t e;
      @(negedge clk);
      awvalid = 1'b1;
      awid = id;
      awlen = len;
      while (!awready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!awready) begin
         note_fail("aw_timeout");
         awvalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      e.id = id;
      e.len = len;
      aw_q.push_back(e);
      $display("AW id=%0h len=%0d", id, len);
   endtask

   // kind: 0 good, 1 early wlast, 2 missing wlast, 3 wrong wid on one beat
   task automatic w_burst(input int kind, input int nb_req, input int stop_after, input bit gaps);
      aw_t e;
      b_t  x;
      int  nbeats;
      int  bad_beat = -1;
      bit  last_flag = 1;
      bit  bad;
      if (aw_q.size() == 0) begin
         note_fail("w_without_aw");
         return;
      end
      e = aw_q.pop_front();
      nbeats = int'(e.len) + 1;
      case (kind)
         1: if (e.len > 0) nbeats = (nb_req > 0) ? nb_req : int'($urandom_range(1, int'(e.len)));
         2: last_flag = 0;
         3: bad_beat = int'($urandom_range(0, int'(e.len)));
         default: ;
      endcase
      // Response rule: OKAY only when every beat carries the AW id and wlast
      // appears exactly on beat awlen+1.
      bad = (bad_beat >= 0) || (nbeats != int'(e.len) + 1) || !last_flag;
      if (stop_after == 0) begin
         x.id = e.id;
         x.resp = bad ? 2'b10 : 2'b00;
         exp_q.push_back(x);
      end
      for (int b = 0; b < nbeats; b++) begin
         int t = 0;
         if (stop_after != 0 && b == stop_after) break;
         @(negedge clk);
         if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
         wvalid = 1'b1;
         wid = (b == bad_beat) ? (e.id ^ 4'h1) : e.id;
         wdata = 32'($urandom);
         wstrb = 4'($urandom);
         wlast = (b == nbeats - 1) && last_flag;
         while (!wready && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (!wready) begin
            note_fail("w_timeout");
            wvalid = 1'b0;
            wlast = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         wvalid = 1'b0;
         wlast = 1'b0;
      end
      $display("W id=%0h len=%0d kind=%0d beats=%0d", e.id, e.len, kind, nbeats);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() > 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() > 0) note_fail("drain_timeout");
      @(negedge clk);
   endtask

   task automatic main_seq();
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 32'(awready), 1);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_bid", 32'(bid), 0);
      chk("rst_bresp", 32'(bresp), 0);
      chk("rst_cnt_ok", 32'(cnt_ok), 0);
      chk("rst_cnt_err", 32'(cnt_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single good burst and response latency
      bready_mode = 1;
      aw_send(4'd3, 8'd3);
      w_burst(0, 0, 0, 0);
      for (int i = 0; i < B_LATENCY - 1; i++) begin
         @(negedge clk);
         chk("lat_bvalid_low", 32'(bvalid), 0);
      end
      @(negedge clk);
      chk("lat_bvalid_high", 32'(bvalid), 1);
      drain();
      chk("t1_cnt_ok", 32'(cnt_ok), 1);
      chk("t1_cnt_err", 32'(cnt_err), 0);

      // Early wlast then a normal burst
      aw_send(4'd1, 8'd3);
      w_burst(1, 2, 0, 0);
      aw_send(4'd2, 8'd1);
      w_burst(0, 0, 0, 0);
      drain();
      chk("t2_cnt_ok", 32'(cnt_ok), 2);
      chk("t2_cnt_err", 32'(cnt_err), 1);

      // Missing wlast, single-beat bursts, wrong wid
      aw_send(4'd7, 8'd1);
      w_burst(2, 0, 0, 0);
      aw_send(4'd4, 8'd2);
      w_burst(3, 0, 0, 0);
      aw_send(4'd5, 8'd0);
      w_burst(0, 0, 0, 0);
      aw_send(4'd6, 8'd0);
      w_burst(2, 0, 0, 0);
      drain();
      chk("t3_cnt_ok", 32'(cnt_ok), 3);
      chk("t3_cnt_err", 32'(cnt_err), 4);

      // Queue full
      for (int i = 0; i < AW_DEPTH; i++) aw_send(4'(8 + i), 8'(i));
      @(negedge clk);
      chk("full_awready", 32'(awready), 0);
      w_burst(0, 0, 0, 0);
      @(negedge clk);
      chk("after_pop_awready", 32'(awready), 1);
      for (int i = 1; i < AW_DEPTH; i++) w_burst(0, 0, 0, 0);
      drain();

      // Backpressure with the next burst already queued and W offered
      bready_mode = 2;
      aw_send(4'd6, 8'd0);
      aw_send(4'd7, 8'd1);
      w_burst(0, 0, 0, 0);
      repeat (B_LATENCY + 1) @(negedge clk);
      wvalid = 1'b1;
      wid = 4'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_bvalid", 32'(bvalid), 1);
         chk("bp_wready", 32'(wready), 0);
         chk("bp_cnt_ok", 32'(cnt_ok), 32'(m_ok));
      end
      wvalid = 1'b0;
      bready_mode = 1;
      w_burst(0, 0, 0, 0);
      drain();
      chk("bp_cnt_final", 32'(cnt_ok), 32'(m_ok));

      // Reset in the middle of a burst
      aw_send(4'd9, 8'd3);
      w_burst(0, 0, 2, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_awready", 32'(awready), 1);
      chk("mid_rst_wready", 32'(wready), 0);
      chk("mid_rst_bvalid", 32'(bvalid), 0);
      chk("mid_rst_bid", 32'(bid), 0);
      chk("mid_rst_bresp", 32'(bresp), 0);
      chk("mid_rst_cnt_ok", 32'(cnt_ok), 0);
      chk("mid_rst_cnt_err", 32'(cnt_err), 0);
      aw_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      aw_send(4'd10, 8'd3);
      w_burst(0, 0, 0, 0);
      drain();
      chk("post_rst_cnt_ok", 32'(cnt_ok), 1);
      chk("post_rst_cnt_err", 32'(cnt_err), 0);

      // Randomized traffic with random bready
      bready_mode = 0;
      for (int it = 0; it < 80; it++) begin
         if (aw_q.size() == 0 || (aw_q.size() < AW_DEPTH && $urandom_range(0, 1) == 1))
            aw_send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 7)));
         else
            w_burst(int'($urandom_range(0, 3)), 0, 0, 1);
      end
      while (aw_q.size() > 0) w_burst(int'($urandom_range(0, 3)), 0, 0, 1);
      drain();
      repeat (2) @(negedge clk);
      chk("final_cnt_ok", 32'(cnt_ok), 32'(m_ok));
      chk("final_cnt_err", 32'(cnt_err), 32'(m_err));
      chk("final_bvalid", 32'(bvalid), 0);
   endtask

   initial begin
      fork
         monitor();
         bready_drv();
         main_seq();
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
